// File: rtl/ctx_switch_unit.sv
// Context save/restore engine: moves PC, GPRs and privilege level
// between the core and a word-aligned memory frame.
module ctx_switch_unit #(
    parameter int DATA_W  = 64,
    parameter int NUM_GPR = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_req,
    input  logic              restore_req,
    input  logic [DATA_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [5:0]        rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_wr_en,
    output logic [5:0]        rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic [3:0]        pl_rd,
    output logic              pl_wr_en,
    output logic [3:0]        pl_wr_data,
    input  logic [DATA_W-1:0] pc_in,
    output logic              pc_wr,
    output logic [DATA_W-1:0] pc_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int NW = NUM_GPR + 2;
    localparam int IW = $clog2(NW);
    localparam logic [IW-1:0] LAST = IW'(NW - 1);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_RD,
        SAVE_WR,
        LOAD,
        COMMIT,
        FIN
    } state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] base_q;
    logic [DATA_W-1:0] dbuf;
    logic              err_q;

    logic              is_pc;
    logic              is_pl;
    logic              is_gpr;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] src;
    logic              commit;

    assign is_pc  = (idx == '0);
    assign is_pl  = (idx == LAST);
    assign is_gpr = !is_pc && !is_pl;
    // Frame offset is 8*i; the sum drops any carry out of DATA_W.
    assign addr   = base_q + (DATA_W'(idx) << 3);

    always_comb begin
        src = rf_rd_data;
        unique case (1'b1)
            is_pc:   src = pc_in;
            is_pl:   src = DATA_W'(pl_rd);
            default: src = rf_rd_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            base_q <= '0;
            dbuf   <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (save_req || restore_req) begin
                        base_q <= base_addr;
                        idx    <= '0;
                        err_q  <= (base_addr[2:0] != 3'b000);
                        if (base_addr[2:0] != 3'b000)
                            state <= FIN;
                        else if (save_req)
                            state <= SAVE_RD;
                        else
                            state <= LOAD;
                    end
                end
                SAVE_RD: begin
                    dbuf  <= src;
                    state <= SAVE_WR;
                end
                SAVE_WR: begin
                    if (mem_ready) begin
                        idx   <= idx + IW'(1);
                        state <= is_pl ? FIN : SAVE_RD;
                    end
                end
                LOAD: begin
                    if (mem_ready) begin
                        dbuf  <= mem_rdata;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    idx   <= idx + IW'(1);
                    state <= is_pl ? FIN : LOAD;
                end
                FIN: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == FIN);
    assign err    = done && err_q;
    assign commit = (state == COMMIT);

    assign rf_rd_addr = (state == SAVE_RD && is_gpr) ? 6'(idx) : 6'd0;

    assign pc_wr      = commit && is_pc;
    assign rf_wr_en   = commit && is_gpr;
    assign pl_wr_en   = commit && is_pl;
    assign pc_data    = pc_wr ? dbuf : '0;
    assign rf_wr_addr = rf_wr_en ? 6'(idx) : 6'd0;
    assign rf_wr_data = rf_wr_en ? dbuf : '0;
    assign pl_wr_data = pl_wr_en ? dbuf[3:0] : 4'd0;

    assign mem_req   = (state == SAVE_WR) || (state == LOAD);
    assign mem_we    = (state == SAVE_WR);
    assign mem_addr  = mem_req ? addr : '0;
    assign mem_wdata = mem_we ? dbuf : '0;

endmodule

// File: doc/ctx_switch_unit.md
CTX_SWITCH_UNIT -- requirements
Module: ctx_switch_unit

Interface
REQ-001 Parameters SHALL be: DATA_W, default 64, datapath width; NUM_GPR, default 3, general registers saved (addresses 1..NUM_GPR).
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- save_req  in  1  start context save
- restore_req  in  1  start context restore
- base_addr  in  DATA_W  frame base byte address
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse, coincident with done
- rf_rd_addr  out  6  register-file read address
- rf_rd_data  in  DATA_W  register-file read data, combinational from rf_rd_addr
- rf_wr_en  out  1  GPR write strobe
- rf_wr_addr  out  6  GPR write address
- rf_wr_data  out  DATA_W  GPR write data
- pl_rd  in  4  current privilege level
- pl_wr_en  out  1  privilege-level write strobe
- pl_wr_data  out  4  privilege-level write data
- pc_in  in  DATA_W  current PC
- pc_wr  out  1  PC write strobe
- pc_data  out  DATA_W  PC write data
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  DATA_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory accepts or completes the request this cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1

Function
REQ-003 The frame SHALL be NUM_GPR+2 words: word 0 = PC, words 1..NUM_GPR = GPR 1..NUM_GPR, word NUM_GPR+1 = PL zero-extended to DATA_W (restore uses bits [3:0]).
REQ-004 The address of word i SHALL be base_addr + 8*i, modulo 2^DATA_W, with no carry out.
REQ-005 The FSM SHALL have the states IDLE, SAVE_RD, SAVE_WR, LOAD, COMMIT and FIN.
REQ-006 In IDLE, save_req SHALL win over restore_req when both are asserted; the unit SHALL latch base_addr and clear the word index i.
REQ-007 Requests arriving while busy=1 SHALL be ignored without queuing.
REQ-008 A request with base_addr[2:0] != 0 SHALL go directly to FIN with err=1 and generate no memory or register-file traffic.
REQ-009 SAVE_RD SHALL set rf_rd_addr=i for GPR words, capture the source word (pc_in, rf_rd_data, or {0,pl_rd}) into a data buffer, and go to SAVE_WR.
REQ-010 SAVE_WR SHALL hold mem_req=1, mem_we=1, mem_addr and mem_wdata=buffer stable until mem_ready=1.
REQ-011 When mem_ready=1 in SAVE_WR, the unit SHALL increment i and go to SAVE_RD, or to FIN after the last word.
REQ-012 LOAD SHALL hold mem_req=1 and mem_we=0 with mem_addr stable; on mem_ready=1 it SHALL capture mem_rdata and go to COMMIT.
REQ-013 COMMIT SHALL assert exactly one strobe for one cycle, chosen by word: pc_wr for word 0, rf_wr_en with rf_wr_addr=i for GPR words, or pl_wr_en for the PL word, with data taken from the buffer.
REQ-014 After COMMIT the unit SHALL increment i and go to LOAD, or to FIN after the last word.
REQ-015 FIN SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 mem_req SHALL be 0 outside SAVE_WR and LOAD.
REQ-018 Latency with mem_ready tied to 1: a request sampled at cycle T SHALL give busy=1 from T+1, done at T+1+2*(NUM_GPR+2) (T+11 at default), and IDLE at the following cycle.
REQ-019 All strobes SHALL be 0 in IDLE; rf_rd_addr SHALL be 0 when not in SAVE_RD.

Reset
REQ-020 rst SHALL force IDLE, i=0 and buffer=0, and drive busy, done, err, mem_req, mem_we, rf_wr_en, pl_wr_en and pc_wr to 0, with all address and data outputs at 0.
REQ-021 rst asserted mid-operation SHALL abort in the same cycle with no further traffic; state already committed SHALL remain as committed.

Verification
REQ-022 Save, mem_ready=1, base=0x1000, PC=0x40, GPR1..3=0x11/0x22/0x33, PL=3 -> writes 0x40@0x1000, 0x11@0x1008, 0x22@0x1010, 0x33@0x1018, 0x3@0x1020; done at T+11.
REQ-023 Restore of the same frame with mem_ready stalled 3 cycles per word -> mem_addr and mem_req stable during each stall, five single-cycle commits in order pc, r1, r2, r3, pl, with done after the last commit.
REQ-024 save_req and restore_req asserted together in IDLE -> save performed (mem_we=1), restore dropped; a restore_req pulse during busy -> ignored.
REQ-025 base=0x1004 -> no mem_req, err=1 and done=1 in the same single cycle, busy high for 1 cycle.
REQ-026 rst asserted during the third LOAD -> next cycle all outputs at 0 and IDLE; PC and r1 hold restored values, r2, r3 and PL unchanged.
REQ-027 base=0xFFFF_FFFF_FFFF_FFF8 save -> word 1 address wraps to 0x0.
